// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the I/D requesters, the arbiter and the
// single-port backing memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_valid;
    logic                  i_busy;
    logic                  i_err;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [3:0]            d_wstrb;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_valid;
    logic                  d_busy;
    logic                  d_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ready;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_valid, i_busy, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_valid, d_busy, d_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_valid, i_busy, i_err,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_valid, d_busy, d_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the
// fetch port and the data port, with response timeout.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input logic           clk,
    input logic           rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t                state, state_d;
    logic                  grant, grant_d;
    logic                  last_grant, last_grant_d;
    logic                  cap_we, cap_we_d;
    logic [ADDR_WIDTH-1:0] cap_addr, cap_addr_d;
    logic [DATA_WIDTH-1:0] cap_wdata, cap_wdata_d;
    logic [3:0]            cap_wstrb, cap_wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         cnt, cnt_d;

    logic in_req;
    logic in_resp;
    logic i_done;
    logic d_done;

    // State and captured-request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_wstrb  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            last_grant <= last_grant_d;
            cap_we     <= cap_we_d;
            cap_addr   <= cap_addr_d;
            cap_wdata  <= cap_wdata_d;
            cap_wstrb  <= cap_wstrb_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt        <= cnt_d;
        end
    end

    // Next state: grant in IDLE, accept in REQ, response or
    // timeout in WAIT, single-cycle RESP.
    always_comb begin
        state_d      = state;
        grant_d      = grant;
        last_grant_d = last_grant;
        cap_we_d     = cap_we;
        cap_addr_d   = cap_addr;
        cap_wdata_d  = cap_wdata;
        cap_wstrb_d  = cap_wstrb;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = cnt;
        unique case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // Contention goes to the port not served last.
                    grant_d      = bus.d_req &
                                   (~bus.i_req | ~last_grant);
                    last_grant_d = grant_d;
                    state_d      = REQ;
                    if (grant_d) begin
                        cap_we_d    = bus.d_we;
                        cap_addr_d  = bus.d_addr;
                        cap_wdata_d = bus.d_wdata;
                        cap_wstrb_d = bus.d_wstrb;
                    end else begin
                        cap_we_d    = 1'b0;
                        cap_addr_d  = bus.i_addr;
                        cap_wdata_d = '0;
                        cap_wstrb_d = '0;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    rdata_d = cap_we ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_req  = (state == REQ);
    assign in_resp = (state == RESP);
    assign i_done  = in_resp & ~grant;
    assign d_done  = in_resp & grant;

    assign bus.mem_req   = in_req;
    assign bus.mem_we    = in_req & cap_we;
    assign bus.mem_addr  = in_req ? cap_addr : '0;
    assign bus.mem_wdata = in_req ? cap_wdata : '0;
    assign bus.mem_wstrb = in_req ? cap_wstrb : '0;

    assign bus.i_valid = i_done;
    assign bus.i_rdata = i_done ? rdata_q : '0;
    assign bus.i_err   = i_done & err_q;
    assign bus.d_valid = d_done;
    assign bus.d_rdata = d_done ? rdata_q : '0;
    assign bus.d_err   = d_done & err_q;

    // Stall requests drop only in the port's own RESP cycle;
    // held low while in reset.
    assign bus.i_busy = rst & bus.i_req & ~i_done;
    assign bus.d_busy = rst & bus.d_req & ~d_done;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the instruction-fetch port (read-only) and the data-memory port (read/write) of the 5-stage pipeline.
- Sequences each access through a request/accept/response handshake. Requests are serviced one at a time, with round-robin priority when both ports request together.
- Produces per-port busy signals that the hazard unit ORs into stall_f (I-port) and into stall of the F/D/E stages (D-port).
- Times out memory responses that never arrive.

Parameters:
- ADDR_WIDTH, 32, byte address width on both ports and on the memory side.
- DATA_WIDTH, 32, data width; fixed at 32 because the byte strobe is 4 bits.
- TIMEOUT, 64, maximum number of cycles in WAIT before the access is aborted with an error. Must be ≥2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_valid.
- i_addr  in  ADDR_WIDTH  fetch byte address.
- i_rdata  out  DATA_WIDTH  fetched word; meaningful only while i_valid=1.
- i_valid  out  1  one-cycle completion pulse for the I-port.
- i_busy  out  1  I-port stall request to the hazard unit.
- d_req  in  1  data request; held with all d_* inputs until d_valid.
- d_we  in  1  1=write, 0=read.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  write data, already lane-aligned.
- d_wstrb  in  4  byte write enables; ignored on reads.
- d_rdata  out  DATA_WIDTH  read data; meaningful only while d_valid=1.
- d_valid  out  1  one-cycle completion pulse for the D-port.
- d_busy  out  1  D-port stall request to the hazard unit.
- d_err  out  1  timeout flag; qualified by d_valid.
- i_err  out  1  timeout flag; qualified by i_valid.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wstrb  out  4  memory byte enables.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory response; also serves as the write acknowledge.
- mem_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Registers: grant (0=I, 1=D), last_grant, a captured request (we, addr, wdata, wstrb), rdata_q, err_q, and a timeout counter of width clog2(TIMEOUT)+1.
- Reset (rst=0, asynchronous): state=IDLE; grant=0; last_grant=0; counter=0. All outputs are 0, including mem_req, i_valid, d_valid, both err flags and both rdata outputs.
- IDLE:
  - Only d_req set: grant D.
  - Only i_req set: grant I.
  - Both set: grant the port that was not last_grant; after reset this means D goes first.
  - On any grant: capture the port's fields (I captures we=0, wstrb=0, wdata=0), set last_grant=grant, go to REQ.
  - No request: stay in IDLE.
- REQ:
  - mem_req=1 and mem_* are driven from the captured registers.
  - On mem_ready=1 at the clock edge, go to WAIT with counter=0.
  - REQ waits indefinitely for mem_ready.
- WAIT:
  - mem_req=0.
  - On mem_rvalid=1: rdata_q=mem_rdata for reads, 0 for writes; err_q=0; go to RESP.
  - If mem_rvalid=0 and counter=TIMEOUT-1: rdata_q=0, err_q=1, go to RESP.
  - Otherwise counter increments.
- RESP (exactly one cycle):
  - The granted port's valid=1, rdata=rdata_q, err=err_q. The other port's outputs stay 0.
  - Next state is IDLE.
- Minimum latency, with mem_ready=1 in REQ and mem_rvalid one cycle later: request seen in IDLE at cycle 0 → REQ at cycle 1 → WAIT at cycle 2 → valid at cycle 3.
  - A request seen in IDLE at cycle 0 gets its valid pulse in cycle 3 at the earliest.
  - Back-to-back service costs one IDLE cycle between transactions.
- Requester contract:
  - The requester may change req and its fields only in the cycle after its valid pulse.
  - Keeping req=1 after valid starts a new transaction in the following IDLE.
  - Changing fields mid-transaction has no effect, because the fields were captured at grant.
- Busy signals (combinational):
  - i_busy = i_req AND NOT (state=RESP AND grant=I).
  - d_busy is defined the same way for the D-port.
  - With no request pending, busy is 0.
- Stray handshakes:
  - mem_rvalid outside WAIT is ignored.
  - mem_ready outside REQ is ignored.
- Reset mid-transaction: the in-flight access is abandoned with no valid pulse. A late mem_rvalid afterwards is ignored.
- A request withdrawn while it is not granted is simply never serviced. Withdrawing a granted request is illegal.

Test Plan:
- Single I read: i_req=1, i_addr=0x00000010, mem_ready=1 in REQ, mem_rvalid=1 with rdata=0x00500093 one cycle later → i_valid pulses exactly at cycle 3, i_rdata=0x00500093, i_err=0, d_valid stays 0.
- D write: d_we=1, d_addr=0x00010004, d_wdata=0xDEADBEEF, d_wstrb=4'b0011 → mem_we=1 and mem_wstrb=0011 while mem_req=1; d_valid pulses with d_rdata=0; i_busy=0 throughout.
- Contention: i_req and d_req both high from reset and held → service order is D, I, D, I; each port's busy falls only during its own RESP cycle.
- Memory backpressure: mem_ready held 0 for 5 cycles in REQ → mem_req and mem_addr stay stable for all 5 cycles; exactly one accept is seen; a single valid pulse follows.
- Timeout with TIMEOUT=8: mem_rvalid never asserted → d_valid=1 and d_err=1 with d_rdata=0, 8 cycles after entry to WAIT. A later stray mem_rvalid is ignored.
- Reset in WAIT: rst=0 for 1 cycle → all outputs 0 immediately and the FSM is in IDLE; a mem_rvalid two cycles later produces no valid pulse; a fresh i_req then completes normally.
